// File: rtl/safebox_core.sv
// safebox_core: lock-control core for the safe box.
// Handles password entry, failed-attempt counting with a timed lockout,
// auto-relock of an idle open box and a password-setting mode.
module safebox_core #(
  parameter int DIGITS          = 4,
  parameter int MAX_TRIES       = 3,
  parameter int LOCKOUT_CYCLES  = 1_500_000_000,
  parameter int AUTOLOCK_CYCLES = 500_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_open_close,
  input  logic                  cmd_set_pw,
  input  logic                  cmd_confirm,
  input  logic                  cmd_clear_pw,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   entry,
  output logic [3:0]            entry_count,
  output logic                  opened,
  output logic                  show_entry,
  output logic                  alarm,
  output logic                  locked_out,
  output logic [3:0]            fail_count
);

  localparam int EW = 4 * DIGITS;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  localparam int IW = $clog2(AUTOLOCK_CYCLES) + 1;

  localparam logic [3:0]    COUNT_MAX  = 4'(DIGITS);
  localparam logic [3:0]    TRIES_MAX  = 4'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(AUTOLOCK_CYCLES);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_OPEN,
    S_SETPW,
    S_LOCKOUT
  } state_t;

  state_t        state;
  logic [EW-1:0] password;
  logic [LW-1:0] lock_timer;
  logic [IW-1:0] idle_timer;
  logic          any_cmd;
  logic          pw_match;
  logic [3:0]    fail_next;

  assign any_cmd  = cmd_open_close | cmd_set_pw | cmd_confirm | cmd_clear_pw;

  // Compare against the registered entry so a final digit and the open
  // command can land on consecutive cycles.
  assign pw_match = (entry_count == COUNT_MAX) && (entry == password);

  // Next failure count, held at MAX_TRIES so it can never wrap.
  always_comb begin
    fail_next = (fail_count >= TRIES_MAX) ? fail_count : fail_count + 4'd1;
  end

  // Lock state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOCKED;
      entry       <= '0;
      entry_count <= '0;
      password    <= '0;
      opened      <= 1'b0;
      show_entry  <= 1'b0;
      alarm       <= 1'b0;
      locked_out  <= 1'b0;
      fail_count  <= '0;
      lock_timer  <= '0;
      idle_timer  <= '0;
    end else if (state == S_LOCKOUT) begin
      if (lock_timer == '0) begin
        state      <= S_LOCKED;
        locked_out <= 1'b0;
        fail_count <= '0;
      end else begin
        lock_timer <= lock_timer - LW'(1);
      end
    end else begin
      if (any_cmd) begin
        entry       <= '0;
        entry_count <= '0;
      end else if (digit_valid && (entry_count < COUNT_MAX)) begin
        entry       <= (entry << 4) | EW'(digit);
        entry_count <= entry_count + 4'd1;
      end

      case (state)
        S_LOCKED: begin
          idle_timer <= '0;
          if (cmd_open_close) begin
            if (pw_match) begin
              state      <= S_OPEN;
              opened     <= 1'b1;
              fail_count <= '0;
              alarm      <= 1'b0;
            end else begin
              fail_count <= fail_next;
              alarm      <= 1'b1;
              if (fail_next == TRIES_MAX) begin
                state      <= S_LOCKOUT;
                locked_out <= 1'b1;
                lock_timer <= LOCK_LOAD;
              end
            end
          end
        end

        S_OPEN, S_SETPW: begin
          if (any_cmd || digit_valid) begin
            idle_timer <= '0;
          end else if (idle_timer == IDLE_LIMIT) begin
            state       <= S_LOCKED;
            opened      <= 1'b0;
            show_entry  <= 1'b0;
            idle_timer  <= '0;
            entry       <= '0;
            entry_count <= '0;
          end else begin
            idle_timer <= idle_timer + IW'(1);
          end

          if (cmd_open_close) begin
            state      <= S_LOCKED;
            opened     <= 1'b0;
            show_entry <= 1'b0;
          end else if (cmd_clear_pw) begin
            password   <= '0;
            state      <= S_OPEN;
            show_entry <= 1'b0;
          end else if (cmd_set_pw) begin
            state      <= S_SETPW;
            show_entry <= 1'b1;
          end else if (cmd_confirm && (state == S_SETPW) &&
                       (entry_count == COUNT_MAX)) begin
            password   <= entry;
            state      <= S_OPEN;
            show_entry <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: doc/safebox_core.md
# safebox_core

Parametrised lock-control core for the safe-box design: N-digit password, failed-attempt counting with timed lockout, auto-relock of an idle open box, and a password-setting mode. It consumes already-debounced single-cycle command pulses and validated keypad digits. It drives the open/alarm/display-mode signals that feed the graph, alarm and seven-segment blocks.

## Interface
- DIGITS, 4: password length in hex digits, 1..8.
- MAX_TRIES, 3: consecutive failed open attempts that trigger lockout, 1..15.
- LOCKOUT_CYCLES, 1_500_000_000: lockout duration in clk cycles (30 s at 50 MHz).
- AUTOLOCK_CYCLES, 500_000_000: idle cycles in OPEN before automatic relock (10 s).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- cmd_open_close  in  1  one-cycle pulse; open attempt when locked, close when open.
- cmd_set_pw  in  1  one-cycle pulse; enter password-setting mode.
- cmd_confirm  in  1  one-cycle pulse; store the entered password.
- cmd_clear_pw  in  1  one-cycle pulse; reset the stored password to all zero.
- digit_valid  in  1  one-cycle strobe; `digit` is valid.
- digit  in  4  keypad hex value.
- entry  out  4*DIGITS  entry buffer; newest digit in bits [3:0].
- entry_count  out  4  number of digits entered, 0..DIGITS.
- opened  out  1  box open (OPEN or SETPW).
- show_entry  out  1  display the entry as digits (SETPW); otherwise the display shows '-'.
- alarm  out  1  alarm request, level.
- locked_out  out  1  in LOCKOUT.
- fail_count  out  4  consecutive failures.

## Operation
- States: LOCKED, OPEN, SETPW, LOCKOUT.
- Stored password register: 4*DIGITS bits. It is zero after reset.
- Digit entry in LOCKED, OPEN and SETPW:
  - With entry_count < DIGITS, digit_valid shifts entry left by 4, inserts the digit at [3:0] and increments entry_count.
  - With entry_count == DIGITS, further digits are ignored.
- Digit entry in LOCKOUT: digits are ignored.
- Every accepted command clears entry and entry_count to 0.
- Command priority within one cycle: open_close > clear_pw > set_pw > confirm. Only the highest-priority command acts. A digit_valid in the same cycle as any command is dropped.
- LOCKED + open_close, when entry_count == DIGITS and entry equals the password:
  - Go to OPEN.
  - fail_count=0, alarm=0.
- LOCKED + open_close, any other case (including a short entry):
  - fail_count+1 and alarm=1.
  - If the new fail_count == MAX_TRIES: go to LOCKOUT and load the lockout timer.
- LOCKED: other commands are ignored, and entry is still cleared.
- LOCKOUT:
  - All inputs are ignored.
  - The timer counts down. On expiry go to LOCKED with fail_count=0; alarm stays 1 until the next successful open.
- OPEN:
  - open_close -> LOCKED.
  - set_pw -> SETPW.
  - clear_pw zeroes the password and the state stays OPEN.
  - confirm is ignored.
  - Auto-relock counter restarts on any command or digit_valid. When it reaches AUTOLOCK_CYCLES idle cycles, go to LOCKED and clear entry.
- SETPW:
  - confirm with entry_count == DIGITS stores entry and goes to OPEN.
  - confirm with a short entry clears entry and stays in SETPW.
  - open_close -> LOCKED; the entry is discarded.
  - clear_pw zeroes the password and goes to OPEN.
  - The auto-relock counter also runs in SETPW and returns the block to LOCKED with the password unchanged.
- Timer widths are $clog2 of the respective parameter plus 1. Counters never wrap; fail_count saturates at MAX_TRIES.

## Timing
- Reset values:
  - state LOCKED.
  - entry=0, entry_count=0.
  - opened=0, show_entry=0, alarm=0, locked_out=0, fail_count=0.
  - password=0, both timers=0.
- All outputs are registered. The effect of an input pulse at edge N is visible after edge N+1.
- Password compare is combinational on the registered entry, so a 4th digit strobe and open_close may arrive on consecutive cycles.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. locked_out is high from the cycle after the failing pulse for LOCKOUT_CYCLES cycles.
- Auto-relock: opened falls AUTOLOCK_CYCLES+1 cycles after the last input.
- rst asserted in any state, mid-entry or mid-timer, restores all reset values on the next edge, including the password.

## Test plan
- Parameters for sim: DIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=20, AUTOLOCK_CYCLES=50.
- Default password: digits 0,0,0,0 then open_close -> opened=1, alarm=0, fail_count=0.
- Three failures: enter 1,2,3,4 then open_close, three times -> alarm=1 after the first, fail_count 1,2,3. locked_out=1 for exactly 20 cycles. Digits during lockout are ignored (entry_count stays 0). Afterwards the state is LOCKED with fail_count=0.
- Change password:
  - Open, then set_pw -> show_entry=1.
  - Enter A,5,C,3 then confirm -> show_entry=0, still opened.
  - Close; open with 0,0,0,0 -> alarm=1; open with A,5,C,3 -> opened=1, alarm=0.
- Short entry and overflow: 1,2 then open_close -> failure. Digits 1..6 -> entry=0x1234, entry_count=4. In SETPW, 3 digits then confirm -> password unchanged, entry cleared.
- Auto-relock and simultaneity:
  - Open, idle 50 cycles -> opened=0.
  - Open, then open_close together with clear_pw -> close only; the password is kept.
  - digit_valid coincident with set_pw -> entry_count=0.
- Reset mid-SETPW after 2 digits -> all outputs zero and the password reverts to 0000.
